// File: rtl/denorm.sv
// Denormalizer: takes a signed normalized 9-bit fraction and an unsigned
// exponent, then shifts the fraction right by that count, one bit per
// cycle. The result is sign-extended to 16 bits. A sticky bit collects
// every bit shifted out, and an error flag marks an out-of-range exponent
// or a fraction that is not normalized.
module denorm #(
  parameter int MAXSH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [8:0]  fr,
  input  logic [3:0]  ex,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] s,
  output logic        sticky,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [4:0] MaxShW = 5'(MAXSH);

  state_e      state_q, state_d;
  logic [8:0]  shReg_q, shReg_d;
  logic [3:0]  count_q, count_d;
  logic        sticky_q, sticky_d;
  logic        err_q, err_d;
  logic        ready_q, ready_d;
  logic        accept;
  logic        exBad;
  logic        frBad;

  // A pair is taken only when the registered ready flag is up, so the
  // first cycle after reset never accepts.
  assign accept = in_valid & ready_q;
  assign exBad  = ({1'b0, ex} > MaxShW);
  assign frBad  = (fr != 9'd0) && (fr[8] == fr[7]);

  // Next-state and datapath: load on accept, shift one bit per SHIFT
  // cycle, hold everything in DONE until the consumer takes it.
  always_comb begin
    state_d  = state_q;
    shReg_d  = shReg_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    err_d    = err_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          count_d  = ex;
          sticky_d = 1'b0;
          err_d    = exBad | frBad;
          if (exBad) begin
            shReg_d = 9'd0;
            state_d = DONE;
          end else begin
            shReg_d = fr;
            state_d = (ex == 4'd0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        shReg_d  = {shReg_q[8], shReg_q[8:1]};
        sticky_d = sticky_q | shReg_q[0];
        count_d  = count_q - 4'd1;
        if (count_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset drops any pending operation and
  // forces every output low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      shReg_q  <= 9'd0;
      count_q  <= 4'd0;
      sticky_q <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shReg_q  <= shReg_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state_q == DONE);
  assign s         = {{7{shReg_q[8]}}, shReg_q};
  assign sticky    = sticky_q;
  assign err       = err_q;

endmodule

// File: tb/tb_denorm.sv
// Randomized scoreboard bench for denorm: the driver pushes the expected
// result of every accepted pair, and the monitor pops and compares it
// whenever the DUT presents a result.
module tb_denorm;

  localparam int MAXSH = 8;

  typedef struct {
    logic [15:0] s;
    logic        sticky;
    logic        err;
    int          acceptCyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  fr = 9'd0;
  logic [3:0]  ex = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] s;
  logic        sticky;
  logic        err;

  int   nChecks = 0;
  int   nFails = 0;
  int   cyc = 0;
  int   stallCnt = 0;
  bit   seenCur = 0;
  bit   chkReady = 0;
  exp_t sb[$];

  denorm #(.MAXSH(MAXSH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fr(fr), .ex(ex), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .sticky(sticky), .err(err)
  );

  // Free-running clock and edge counter used for latency measurement.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference result computed directly from the arithmetic meaning of the
  // operation: value / 2^ex with truncation toward minus infinity.
  function automatic exp_t model(input logic [8:0] f, input logic [3:0] e, input int c);
    exp_t r;
    int   fv;
    fv = int'($signed(f));
    r.acceptCyc = c;
    if (int'(e) > MAXSH) begin
      r.s = 16'd0;
      r.sticky = 1'b0;
      r.err = 1'b1;
      r.lat = 1;
    end else begin
      r.s = 16'(fv >>> e);
      r.sticky = ((int'(f) & ((1 << e) - 1)) != 0);
      r.err = (f != 9'd0) && (f[8] == f[7]);
      r.lat = int'(e) + 1;
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [8:0] f, input logic [3:0] e);
    int waitCnt = 0;
    @(negedge clk);
    fr = f;
    ex = e;
    in_valid = 1'b1;
    while (!in_ready && waitCnt < 300) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(model(f, e, cyc));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    fr = 9'($urandom);
    ex = 4'($urandom);
  endtask

  // Consumer: random back-pressure, or a forced stall counted in DONE cycles.
  always @(negedge clk) begin
    if (stallCnt > 0) begin
      out_ready = 1'b0;
      if (out_valid) stallCnt = stallCnt - 1;
    end else begin
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compares every presented result against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (chkReady) begin
        checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
        chkReady = 0;
      end
      if (out_valid) begin
        checkOutput("in_ready_low_in_done", 32'(in_ready), 32'd0);
        if (sb.size() == 0) begin
          checkOutput("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          if (!seenCur) begin
            checkOutput("latency", 32'(cyc - sb[0].acceptCyc), 32'(sb[0].lat));
            seenCur = 1;
          end
          checkOutput("s", 32'(s), 32'(sb[0].s));
          checkOutput("sticky", 32'(sticky), 32'(sb[0].sticky));
          checkOutput("err", 32'(err), 32'(sb[0].err));
          if (out_ready) begin
            void'(sb.pop_front());
            seenCur = 0;
            chkReady = 1;
          end
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_s"}, 32'(s), 32'd0);
    checkOutput({tag, "_sticky"}, 32'(sticky), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic drain();
    int waitCnt = 0;
    while (sb.size() != 0 && waitCnt < 1000) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [8:0] f;
    logic [3:0] e;
    int         pick;
    $display("[TB] starting denorm bench");

    // Reset held across a couple of edges; outputs must read zero.
    repeat (2) @(negedge clk);
    #2;
    checkResetOutputs("reset");
    reset = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Directed cases from the worked examples.
    applyStimulus(9'h0C0, 4'd3);
    applyStimulus(9'h140, 4'd4);
    applyStimulus(9'h0C1, 4'd1);
    applyStimulus(9'h0C0, 4'd0);
    applyStimulus(9'h0C0, 4'd9);
    applyStimulus(9'h020, 4'd2);
    applyStimulus(9'h000, 4'd8);
    applyStimulus(9'h1FF, 4'd8);
    drain();

    // Consumer stalls five cycles in DONE; monitor checks stability.
    stallCnt = 5;
    applyStimulus(9'h0C1, 4'd2);
    drain();

    // Reset in the middle of a long shift must discard the operation.
    applyStimulus(9'h0C0, 4'd8);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    seenCur = 0;
    chkReady = 0;
    #2;
    checkResetOutputs("midshift_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2;
    checkOutput("in_ready_after_midshift_reset", 32'(in_ready), 32'd1);
    applyStimulus(9'h0C0, 4'd2);
    drain();

    // Randomized pairs: mostly normalized fractions, some zero or raw.
    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 19);
      if (pick < 3) f = 9'd0;
      else if (pick < 6) f = 9'($urandom);
      else if (pick < 13) f = {2'b01, 7'($urandom)};
      else f = {2'b10, 7'($urandom)};
      e = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, MAXSH));
      applyStimulus(f, e);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    nFails++;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/denorm.md
DENORM -- requirements
Module: denorm

Interface
REQ-001: Parameter MAXSH, default 8; largest legal shift count, and any ex above it is an error.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: reset  input  1  asynchronous, active-low reset.
REQ-004: in_valid  input  1  fr/ex pair offered.
REQ-005: in_ready  output  1  block can accept a pair.
REQ-006: fr  input  9  signed normalized fraction; fr[8]!=fr[7] unless fr==0.
REQ-007: ex  input  4  unsigned right-shift count restoring fixed-point value.
REQ-008: out_valid  output  1  result available.
REQ-009: out_ready  input  1  consumer takes result.
REQ-010: s  output  16  signed result, fr arithmetic-shifted right by ex, sign-extended to 16 bits.
REQ-011: sticky  output  1  OR of all bits shifted out.
REQ-012: err  output  1  ex>MAXSH or fr not normalized.

Function
REQ-013: The FSM SHALL have three states, IDLE, SHIFT and DONE, and SHALL enter IDLE on reset.
REQ-014: in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015: A transfer SHALL occur when in_valid&in_ready at a clk edge, and that edge SHALL latch fr into a 9-bit shift register, ex into a count register and clear sticky.
REQ-016: On acceptance with ex==0, the FSM SHALL go IDLE->DONE, so out_valid is asserted 1 cycle after accept.
REQ-017: On acceptance with 1<=ex<=MAXSH, the FSM SHALL go IDLE->SHIFT.
REQ-018: On acceptance with ex>MAXSH, the FSM SHALL go IDLE->DONE with s=0, sticky=0 and err=1; no shifting SHALL occur.
REQ-019: Each SHIFT cycle SHALL perform one arithmetic right shift by 1 (MSB replicated), OR the bit shifted out into sticky, and decrement count.
REQ-020: When the decremented count reaches 0, SHIFT SHALL go to DONE, giving total latency ex+1 cycles from accept to out_valid.
REQ-021: err SHALL be set at acceptance when fr!=0 and fr[8]==fr[7]; the shift SHALL still be performed normally.
REQ-022: In DONE, s, sticky and err SHALL be held stable until out_valid&out_ready, after which the FSM SHALL return to IDLE on the next edge.
REQ-023: No new input SHALL be accepted in the same cycle as the output handshake; the earliest next accept is the cycle after IDLE is re-entered.
REQ-024: s[15:9] SHALL equal s[8] at all times.
REQ-025: in_valid deasserting while in SHIFT or DONE SHALL have no effect.
REQ-026: fr==0 SHALL yield s=0 and sticky=0 for any legal ex.
REQ-027: Outputs SHALL be registered, with no combinational path from fr/ex to s/sticky/err.

Reset
REQ-028: While reset==0, outputs SHALL be asynchronously forced to in_ready=0, out_valid=0, s=0, sticky=0 and err=0, and state SHALL be IDLE.
REQ-029: After reset deasserts, in_ready SHALL be 1 on the first clk edge's following cycle.
REQ-030: Reset asserted mid-SHIFT or in DONE SHALL discard the pending operation with no output handshake.

Verification
REQ-031: fr=9'h0C0, ex=3, out_ready=1 -> out_valid 4 cycles after accept, s=16'h0018, sticky=0, err=0.
REQ-032: fr=9'h140, ex=4 -> s=16'hFFF4, sticky=0, err=0, latency 5 cycles.
REQ-033: fr=9'h0C1, ex=1 -> s=16'h0060, sticky=1; then fr=9'h0C0, ex=0 -> s=16'h00C0, sticky=0, latency 1 cycle.
REQ-034: ex=9 -> out_valid 1 cycle after accept, s=0, err=1; fr=9'h020, ex=2 -> s=16'h0008, err=1.
REQ-035: out_ready=0 for 5 cycles in DONE -> s/sticky/out_valid stable and in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-036: reset pulsed low during SHIFT of fr=9'h0C0, ex=8 -> out_valid never asserts for that pair; the next pair fr=9'h0C0, ex=2 -> s=16'h0030.
